imem_fetch_bank: RTL and testbench

Parametrised multi-issue instruction memory for the superscalar front end. It returns ISSUE_W consecutive 32-bit RISC-V instruction words per fetch behind a valid/ready handshake, with a registered response stage, stall hold, flush, and a runtime program-load write port. Out-of-range and misaligned fetches are flagged. It sits between the PC/fetch-control stage and the decode stage.

---
 rtl/imem_fetch_bank.sv | 115 +++++++++++
 tb/tb_imem_fetch_bank.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_bank.sv
// imem_fetch_bank: multi-issue instruction memory between PC/fetch control and decode.
// Returns ISSUE_W consecutive 32-bit words per accepted fetch, one cycle after accept,
// through a registered response stage that holds under stall and clears on flush.
// A program-load port writes the array independently of the fetch handshake.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready/req_pc   fetch request handshake, byte address of lane 0
//   rsp_valid/rsp_ready          response handshake towards decode
//   rsp_pc/rsp_instr/rsp_mask    response bundle (lane k in rsp_instr[32k+31:32k])
//   rsp_fault                    misaligned request or lane 0 out of range
//   flush                        drops held response and any same-cycle request
//   ld_en/ld_addr/ld_data        program-load write port (word index)
//   fetch_cnt                    accepted-request counter, wraps at 2^32
module imem_fetch_bank #(
    parameter int unsigned ISSUE_W   = 2,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD  = 32'h00000013,
    parameter string       INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_pc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_pc,
    output logic [32*ISSUE_W-1:0] rsp_instr,
    output logic [ISSUE_W-1:0]    rsp_mask,
    output logic                  rsp_fault,
    input  logic                  flush,
    input  logic                  ld_en,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [31:0]           ld_data,
    output logic [31:0]           fetch_cnt
);

    // One extra bit so the lane index can show it ran past the last word.
    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef logic [31:0] mem_t [DEPTH];

    // Power-up image: NOP everywhere.
    function automatic mem_t init_image();
        mem_t img;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            img[i] = NOP_WORD;
        end
        return img;
    endfunction

    mem_t mem = init_image();

    logic                  accept;
    logic                  pc_fault;
    logic [ADDR_W-1:0]     base_idx;
    logic [IDX_W-1:0]      lane_idx;
    logic [32*ISSUE_W-1:0] lane_instr;
    logic [ISSUE_W-1:0]    lane_mask;

    // A new request is taken only when the response slot is free or draining.
    assign req_ready = !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign base_idx = req_pc[ADDR_W+1:2];
    // Lane 0 is out of range exactly when any byte-address bit above the array is set.
    assign pc_fault = (req_pc[1:0] != 2'b00) || (req_pc[31:ADDR_W+2] != '0);

    // Lane gather; lanes never wrap past the last word, they become NOP instead.
    always_comb begin
        lane_instr = {ISSUE_W{NOP_WORD}};
        lane_mask  = '0;
        lane_idx   = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            lane_idx = {1'b0, base_idx} + IDX_W'(k);
            if (!pc_fault && !lane_idx[ADDR_W]) begin
                lane_instr[32*k +: 32] = mem[lane_idx[ADDR_W-1:0]];
                lane_mask[k]           = 1'b1;
            end
        end
    end

    // Response register: rst > flush > accept > consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_pc    <= '0;
            rsp_instr <= {ISSUE_W{NOP_WORD}};
            rsp_mask  <= '0;
            rsp_fault <= 1'b0;
            fetch_cnt <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_pc    <= req_pc;
            rsp_instr <= lane_instr;
            rsp_mask  <= lane_mask;
            rsp_fault <= pc_fault;
            fetch_cnt <= fetch_cnt + 32'd1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Program-load write; the same-edge fetch above samples the old word (read-first).
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_fetch_bank.sv
// Testbench for imem_fetch_bank: three instances (ISSUE_W = 4, 2, 1) share stimulus and
// are compared against a transaction-level memory/response model kept in the bench.
module tb_imem_fetch_bank;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int unsigned BW  = 330;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        rsp_ready;
    logic        flush;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic         rr4, rr2, rr1;
    logic         v4, v2, v1;
    logic [31:0]  p4, p2, p1;
    logic [127:0] i4;
    logic [63:0]  i2;
    logic [31:0]  i1;
    logic [3:0]   m4;
    logic [1:0]   m2;
    logic [0:0]   m1;
    logic         f4, f2, f1;
    logic [31:0]  c4, c2, c1;

    imem_fetch_bank #(.ISSUE_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr4), .req_pc(req_pc),
        .rsp_valid(v4), .rsp_ready(rsp_ready), .rsp_pc(p4), .rsp_instr(i4), .rsp_mask(m4),
        .rsp_fault(f4), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_cnt(c4));

    imem_fetch_bank #(.ISSUE_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr2), .req_pc(req_pc),
        .rsp_valid(v2), .rsp_ready(rsp_ready), .rsp_pc(p2), .rsp_instr(i2), .rsp_mask(m2),
        .rsp_fault(f2), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_cnt(c2));

    imem_fetch_bank #(.ISSUE_W(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1), .req_pc(req_pc),
        .rsp_valid(v1), .rsp_ready(rsp_ready), .rsp_pc(p1), .rsp_instr(i1), .rsp_mask(m1),
        .rsp_fault(f1), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_cnt(c1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combined view of all three response bundles.
    logic [BW-1:0] act_bundle;
    assign act_bundle = {i4, m4, f4, p4, i2, m2, f2, p2, i1, m1, f1, p1};

    // Reference model state.
    logic [31:0]   model_mem [1024];
    logic          exp_valid;
    logic [BW-1:0] exp_bundle;
    logic [31:0]   exp_cnt;
    logic [BW-1:0] rst_bundle;

    int n_tests;
    int n_fail;

    // Expected bundle for a fetch at byte address pc, for all three issue widths.
    function automatic logic [BW-1:0] model_bundle(input logic [31:0] pc);
        logic [127:0] ins;
        logic [3:0]   msk;
        logic         flt;
        int unsigned  base;
        flt  = (pc % 4 != 0) || (pc >= 32'd4096);
        base = pc / 4;
        for (int k = 0; k < 4; k++) begin
            if (!flt && (base + k) < 1024) begin
                ins[32*k +: 32] = model_mem[base + k];
                msk[k]          = 1'b1;
            end else begin
                ins[32*k +: 32] = NOP;
                msk[k]          = 1'b0;
            end
        end
        return {ins, msk, flt, pc, ins[63:0], msk[1:0], flt, pc, ins[31:0], msk[0], flt, pc};
    endfunction

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic          acc;
        logic [BW-1:0] nb;
        acc = req_valid && !flush && (!exp_valid || rsp_ready);
        nb  = model_bundle(req_pc);
        @(posedge clk);
        if (rst) begin
            exp_valid  = 1'b0;
            exp_bundle = rst_bundle;
            exp_cnt    = 32'd0;
        end else if (flush) begin
            exp_valid = 1'b0;
        end else if (acc) begin
            exp_valid  = 1'b1;
            exp_bundle = nb;
            exp_cnt    = exp_cnt + 32'd1;
        end else if (rsp_ready) begin
            exp_valid = 1'b0;
        end
        if (ld_en) model_mem[ld_addr] = ld_data;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0; flush = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        n_tests++;
        if ({v4, v2, v1} !== 3'b000) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=000", {v4, v2, v1});
        end
        n_tests++;
        if (act_bundle !== rst_bundle) begin
            n_fail++; $display("FAIL reset_bundle got=%h exp=%h", act_bundle, rst_bundle);
        end
        n_tests++;
        if ({c4, c2, c1} !== 96'd0) begin
            n_fail++; $display("FAIL reset_cnt got=%h exp=0", {c4, c2, c1});
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({rr4, rr2, rr1} !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=111", {rr4, rr2, rr1});
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 1024; i++) begin
            ld_en   = 1'b1;
            ld_addr = 10'(i);
            ld_data = (i < 8) ? 32'h100 + 32'(i) : $urandom;
            tick();
        end
        ld_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'd0; pcs[1] = 32'd8; pcs[2] = 32'd16;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            req_pc = pcs[n];
            tick();
            n_tests++;
            if (v2 !== 1'b1 || i2 !== {32'h101 + 32'(2*n), 32'h100 + 32'(2*n)} || m2 !== 2'b11) begin
                n_fail++;
                $display("FAIL b2b_beat%0d got v=%b i=%h m=%b exp v=1 i=%h m=11", n, v2, i2, m2,
                         {32'h101 + 32'(2*n), 32'h100 + 32'(2*n)});
            end
            n_tests++;
            if (act_bundle !== exp_bundle) begin
                n_fail++; $display("FAIL b2b_bundle%0d got=%h exp=%h", n, act_bundle, exp_bundle);
            end
        end
        n_tests++;
        if ({c4, c2, c1} !== {3{32'd3}}) begin
            n_fail++; $display("FAIL b2b_cnt got=%h exp=3 each", {c4, c2, c1});
        end
        req_valid = 1'b0;
        tick();
        n_tests++;
        if ({v4, v2, v1} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_drain got=%b exp=000", {v4, v2, v1});
        end
    endtask

    task automatic test_stall();
        req_valid = 1'b1; rsp_ready = 1'b1; req_pc = 32'd8;
        tick();
        rsp_ready = 1'b0;
        req_pc    = 32'h40;
        for (int n = 0; n < 3; n++) begin
            #1;
            n_tests++;
            if ({rr4, rr2, rr1} !== 3'b000) begin
                n_fail++; $display("FAIL stall_ready%0d got=%b exp=000", n, {rr4, rr2, rr1});
            end
            tick();
            n_tests++;
            if (v2 !== 1'b1 || p2 !== 32'd8 || act_bundle !== exp_bundle || c2 !== exp_cnt) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b pc=%h b=%h cnt=%0d exp pc=8 b=%h cnt=%0d",
                         n, v2, p2, act_bundle, c2, exp_bundle, exp_cnt);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (rr2 !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready got=%b exp=1", rr2);
        end
        tick();
        n_tests++;
        if (v2 !== 1'b1 || p2 !== 32'h40 || act_bundle !== exp_bundle) begin
            n_fail++; $display("FAIL stall_next got pc=%h b=%h exp pc=40 b=%h", p2, act_bundle, exp_bundle);
        end
        req_valid = 1'b0;
        tick();
        n_tests++;
        if (v2 !== 1'b0) begin
            n_fail++; $display("FAIL stall_single_beat got v=%b exp=0", v2);
        end
    endtask

    task automatic test_boundary();
        req_valid = 1'b1; rsp_ready = 1'b1; req_pc = 32'hFFC;
        tick();
        n_tests++;
        if (i2 !== {NOP, model_mem[1023]} || m2 !== 2'b01 || f2 !== 1'b0 ||
            m4 !== 4'b0001 || m1 !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_last got i=%h m2=%b m4=%b m1=%b f=%b exp i=%h m2=01 m4=0001 m1=1 f=0",
                     i2, m2, m4, m1, f2, {NOP, model_mem[1023]});
        end
        req_pc = 32'h1000;
        tick();
        n_tests++;
        if (i4 !== {4{NOP}} || i2 !== {2{NOP}} || m4 !== 4'b0 || m2 !== 2'b0 ||
            {f4, f2, f1} !== 3'b111) begin
            n_fail++;
            $display("FAIL boundary_oor got i2=%h m2=%b m4=%b f=%b exp NOPs, mask 0, fault 1",
                     i2, m2, m4, {f4, f2, f1});
        end
        for (int n = 0; n < 6; n++) begin
            req_pc = 32'hFF0 + 32'(4 * n);
            tick();
            n_tests++;
            if (act_bundle !== exp_bundle) begin
                n_fail++; $display("FAIL boundary_sweep%0d got=%h exp=%h", n, act_bundle, exp_bundle);
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        req_valid = 1'b1; rsp_ready = 1'b1; req_pc = 32'h6;
        tick();
        n_tests++;
        if (f2 !== 1'b1 || m2 !== 2'b00 || p2 !== 32'h6 || i2 !== {2{NOP}}) begin
            n_fail++; $display("FAIL misaligned got f=%b m=%b pc=%h i=%h exp f=1 m=00 pc=6", f2, m2, p2, i2);
        end
        for (int n = 0; n < 4; n++) begin
            req_pc = {$urandom_range(1023, 0), 2'b00} | 32'($urandom_range(3, 1));
            tick();
            n_tests++;
            if (act_bundle !== exp_bundle) begin
                n_fail++; $display("FAIL misaligned_rand%0d got=%h exp=%h", n, act_bundle, exp_bundle);
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        req_valid = 1'b1; rsp_ready = 1'b1; req_pc = 32'h20;
        tick();
        rsp_ready = 1'b0; req_valid = 1'b0;
        tick();
        cnt_before = exp_cnt;
        flush = 1'b1; req_valid = 1'b1; req_pc = 32'h30;
        #1;
        n_tests++;
        if ({rr4, rr2, rr1} !== 3'b000) begin
            n_fail++; $display("FAIL flush_ready got=%b exp=000", {rr4, rr2, rr1});
        end
        tick();
        n_tests++;
        if ({v4, v2, v1} !== 3'b000 || c2 !== cnt_before) begin
            n_fail++; $display("FAIL flush_drop got v=%b cnt=%0d exp v=000 cnt=%0d", {v4, v2, v1}, c2, cnt_before);
        end
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        n_tests++;
        if (v2 !== 1'b0 || c2 !== cnt_before) begin
            n_fail++; $display("FAIL flush_after got v=%b cnt=%0d exp v=0 cnt=%0d", v2, c2, cnt_before);
        end
    endtask

    task automatic test_load_read_first();
        req_valid = 1'b1; rsp_ready = 1'b1; req_pc = 32'h10;
        ld_en = 1'b1; ld_addr = 10'd4; ld_data = 32'hDEADBEEF;
        tick();
        n_tests++;
        if (i2[31:0] !== 32'h104 || i4[31:0] !== 32'h104 || i1 !== 32'h104) begin
            n_fail++; $display("FAIL readfirst_old got %h/%h/%h exp 104", i4[31:0], i2[31:0], i1);
        end
        ld_en = 1'b0;
        tick();
        n_tests++;
        if (i2[31:0] !== 32'hDEADBEEF || i4[31:0] !== 32'hDEADBEEF || i1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL readfirst_new got %h/%h/%h exp deadbeef", i4[31:0], i2[31:0], i1);
        end
        n_tests++;
        if (m4 !== 4'b1111 || m2 !== 2'b11 || m1 !== 1'b1 || act_bundle !== exp_bundle) begin
            n_fail++; $display("FAIL readfirst_masks got m4=%b m2=%b m1=%b b=%h exp=%h", m4, m2, m1, act_bundle, exp_bundle);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        req_valid = 1'b1; rsp_ready = 1'b1; req_pc = 32'h0;
        tick();
        rsp_ready = 1'b0;
        rst = 1'b1; ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hCAFEF00D;
        tick();
        n_tests++;
        if ({v4, v2, v1} !== 3'b000 || act_bundle !== rst_bundle || c2 !== 32'd0) begin
            n_fail++; $display("FAIL rststall_clear got v=%b cnt=%0d b=%h", {v4, v2, v1}, c2, act_bundle);
        end
        rst = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1; req_pc = 32'h14;
        #1;
        n_tests++;
        if (rr2 !== 1'b1) begin
            n_fail++; $display("FAIL rststall_ready got=%b exp=1", rr2);
        end
        tick();
        n_tests++;
        if (i2[31:0] !== 32'hCAFEF00D || c2 !== 32'd1) begin
            n_fail++; $display("FAIL rststall_write got lane0=%h cnt=%0d exp cafef00d cnt=1", i2[31:0], c2);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            req_valid = ($urandom_range(3, 0) != 0);
            rsp_ready = ($urandom_range(2, 0) != 0);
            flush     = ($urandom_range(15, 0) == 0);
            ld_en     = ($urandom_range(3, 0) == 0);
            ld_addr   = 10'($urandom_range(1023, 0));
            ld_data   = $urandom;
            case ($urandom_range(4, 0))
                0, 1:    req_pc = {20'd0, 10'($urandom_range(1023, 0)), 2'b00};
                2:       req_pc = 32'hFF0 + 32'(4 * $urandom_range(7, 0));
                3:       req_pc = 32'($urandom_range(4095, 0));
                default: req_pc = $urandom;
            endcase
            #1;
            n_tests++;
            if (rr2 !== (!flush && (!exp_valid || rsp_ready)) || rr4 !== rr2 || rr1 !== rr2) begin
                n_fail++; $display("FAIL rand_ready%0d got=%b%b%b", n, rr4, rr2, rr1);
            end
            tick();
            n_tests++;
            if ({v4, v2, v1} !== {3{exp_valid}} || {c4, c2, c1} !== {3{exp_cnt}} ||
                (exp_valid && act_bundle !== exp_bundle)) begin
                n_fail++;
                $display("FAIL rand_rsp%0d got v=%b cnt=%0d b=%h exp v=%b cnt=%0d b=%h",
                         n, {v4, v2, v1}, c2, act_bundle, exp_valid, exp_cnt, exp_bundle);
            end
        end
        req_valid = 1'b0; flush = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_valid  = 1'b0;
        exp_cnt    = 32'd0;
        rst_bundle = {{4{NOP}}, 4'b0, 1'b0, 32'd0, {2{NOP}}, 2'b0, 1'b0, 32'd0, NOP, 1'b0, 1'b0, 32'd0};
        exp_bundle = rst_bundle;
        for (int i = 0; i < 1024; i++) model_mem[i] = NOP;

        test_reset();
        preload();
        test_back_to_back();
        test_stall();
        test_boundary();
        test_misaligned();
        test_flush();
        test_load_read_first();
        test_reset_mid_stall();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
